vga_pixel_compositor: RTL and testbench
=======================================

// Module: vga_pixel_compositor
// PURPOSE
//  Pipelined pixel back end that sits directly downstream of the VGA memory-address generator.
//  - Consumes per-pixel map, item and character selectors and offsets.
//  - Issues reads to the tile, item and sprite colour-index ROMs.
//  - Resolves layer priority and transparency, then maps the winning index through the palette.
//  - Drives RGB and sync to the DAC, with sync delayed to stay aligned with the pixel.
// PARAMETERS
//  BLINK_FRAMES  16  frames per power-pellet / fright-flash blink half-period (>=1)
//  CIDX_W        4   colour-index width returned by every ROM; index 0 = transparent
// PORTS
//  i_clk            in   1   pixel clock
//  i_rst            in   1   asynchronous, active-high reset
//  i_show_en        in   1   active-video qualifier, same cycle as the selectors
//  i_hsync          in   1   raw hsync, active-low, same cycle as the selectors
//  i_vsync          in   1   raw vsync, active-low, same cycle as the selectors
//  i_frame_start    in   1   one-cycle pulse per frame; advances the blink counter
//  i_mem_select     in   2   [1]=character layer valid, [0]=board layer valid
//  i_address_map    in   8   tile index
//  i_address_item   in   2   item code: 0 none, 1 dot, 2 power pellet, 3 reserved (treated as none)
//  i_which_char     in   4   0 pacman, 1..4 blinky/pinky/inky/clyde, others invalid
//  i_tile_offset    in   6   pixel index within an 8x8 tile
//  i_char_offset    in   8   pixel index within a 16x16 sprite
//  i_fright         in   1   ghosts are drawn with the frightened palette
//  i_fright_flash   in   1   frightened ghosts alternate white/blue on blink phase
//  o_tile_rom_addr  out  14  {address_map, tile_offset}
//  i_tile_rom_data  in   CIDX_W  tile colour index; sync ROM, 1-cycle read latency
//  o_item_rom_addr  out  8   {address_item, tile_offset}
//  i_item_rom_data  in   CIDX_W  item colour index; 1-cycle read latency
//  o_char_rom_addr  out  12  {which_char, char_offset}
//  i_char_rom_data  in   CIDX_W  sprite colour index; 1-cycle read latency
//  o_r, o_g, o_b    out  8 each  pixel colour
//  o_hsync, o_vsync out  1   delayed syncs
//  o_blank          out  1   1 = outside active video
// BEHAVIOUR
//  Pipeline (fixed latency 3; inputs at cycle N appear at outputs at cycle N+3):
//  - S1 (N+1): register all selectors, ROM addresses, sync and show_en.
//  - S2 (N+2): ROM data valid; register control sideband alongside it.
//  - S3 (N+3): resolve the pixel, run the palette lookup and register all outputs.
//  Priority at S3, first match wins:
//  1. If show_en=0 or mem_select=00: output black and o_blank=1.
//  2. Character layer: select[1]=1, char index !=0 and which_char<=4.
//     - Ghost (1..4) with fright=1 uses FRIGHT_BLUE.
//     - If fright_flash=1 and blink_phase=1, use FRIGHT_WHITE instead.
//  3. Item layer: select[0]=1, item code 1 or 2, and item index !=0.
//     - A pellet (code 2) is suppressed while blink_phase=1.
//  4. Board layer: select[0]=1 uses the tile index, including index 0, which maps to black.
//  5. Anything else outputs black.
//  Blink counter:
//  - 5-bit frame count; increments on i_frame_start.
//  - On reaching BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase.
//  - BLINK_FRAMES=1 toggles the phase every frame.
//  - Phase is sampled in S3 only, so it never changes mid-pixel.
//  Reset values:
//  - RGB 0; o_hsync=1, o_vsync=1; o_blank=1.
//  - All ROM addresses 0; all pipeline regs cleared (show_en=0); blink count 0, phase 0.
//  - Reset mid-frame flushes the pipe: the first 3 cycles after release output black with blank=1.
//  - If i_frame_start coincides with reset, reset wins and the pulse is lost.
//  Widths and address packing:
//  - Addresses are pure concatenations, with no arithmetic and no overflow possible.
//  - Palette output is 24 bits; unused palette entries map to black.
// STRUCTURE
//  - vga_pkg (shared package) holds:
//    - item codes ITEM_NONE/DOT/PELLET;
//    - char ids CHAR_PACMAN..CHAR_CLYDE;
//    - palette constants, including FRIGHT_BLUE and FRIGHT_WHITE;
//    - the PIPE_LAT=3 constant;
//    - the pixel_rgb_t struct {r,g,b}.
//  - Sub-module vga_palette_lut: combinational, CIDX_W index plus class -> pixel_rgb_t. It is instantiated once, in S3.
//  - Everything else (the three pipeline stages and the blink counter) stays in this module.
// TESTING
//  1. Reset: hold i_rst with random inputs.
//     -> o_r/g/b=0, hsync=vsync=1, blank=1.
//     -> After release, first valid pixel appears exactly 3 cycles after the first show_en=1.
//  2. Layering: select=11, char idx 5, item idx 3, tile idx 2.
//     -> Palette[5] at N+3.
//     -> Char idx 0 gives palette[item 3]; char and item both 0 give palette[2].
//  3. Pellet blink, BLINK_FRAMES=4, item code 2, idx 7:
//     -> Visible for frame_start pulses 0..3.
//     -> Hidden (tile shows) for pulses 4..7.
//     -> Visible again at pulse 8.
//  4. Fright: which_char=2, char idx 9, fright=1.
//     -> FRIGHT_BLUE.
//     -> Add fright_flash=1 with phase=1: FRIGHT_WHITE.
//     -> which_char=0 under fright stays palette[9].
//  5. Sync alignment: toggle i_hsync/i_vsync with a pixel ramp.
//     -> Syncs and RGB are both delayed exactly 3 cycles; show_en=0 forces black with blank=1.
//  6. Async reset asserted mid-line, between clock edges:
//     -> Outputs go to reset values immediately, not at the next edge.
//     -> Blink phase returns to 0.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and constants for the VGA pixel back end
package vga_pkg;

  localparam int PIPE_LAT = 3;

  typedef enum logic [1:0] {
    ITEM_NONE   = 2'd0,
    ITEM_DOT    = 2'd1,
    ITEM_PELLET = 2'd2,
    ITEM_RSVD   = 2'd3
  } item_code_e;

  localparam logic [3:0] CHAR_PACMAN = 4'd0;
  localparam logic [3:0] CHAR_BLINKY = 4'd1;
  localparam logic [3:0] CHAR_PINKY  = 4'd2;
  localparam logic [3:0] CHAR_INKY   = 4'd3;
  localparam logic [3:0] CHAR_CLYDE  = 4'd4;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_rgb_t;

  typedef enum logic [1:0] {
    PAL_BLACK,
    PAL_INDEX,
    PAL_FRIGHT_BLUE,
    PAL_FRIGHT_WHITE
  } pal_class_e;

  localparam pixel_rgb_t RGB_BLACK    = 24'h000000;
  localparam pixel_rgb_t FRIGHT_BLUE  = 24'h2121de;
  localparam pixel_rgb_t FRIGHT_WHITE = 24'hdedeff;

  // Entries 13..15 are unused and stay black.
  function automatic pixel_rgb_t pal_lookup(input logic [3:0] idx);
    case (idx)
      4'd1:    return 24'hff0000;
      4'd2:    return 24'hffb8ff;
      4'd3:    return 24'h00ffff;
      4'd4:    return 24'hffb852;
      4'd5:    return 24'hffff00;
      4'd6:    return 24'h2121ff;
      4'd7:    return 24'hffb897;
      4'd8:    return 24'hffffff;
      4'd9:    return 24'h47b8ff;
      4'd10:   return 24'h00ff00;
      4'd11:   return 24'hde9751;
      4'd12:   return 24'h21ffde;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_palette_lut.sv
// rtl/vga_palette_lut.sv - colour index plus class to 24-bit RGB
module vga_palette_lut
  import vga_pkg::*;
#(
  parameter int CIDX_W = 4
) (
  input  logic [CIDX_W-1:0] idx,
  input  pal_class_e        cls,
  output pixel_rgb_t        rgb
);

  logic [3:0] idx_lo;
  logic       idx_hi;

  assign idx_lo = idx[3:0];
  assign idx_hi = 32'(idx) > 32'd15;

  always_comb begin
    rgb = RGB_BLACK;
    case (cls)
      PAL_INDEX:        rgb = idx_hi ? RGB_BLACK : pal_lookup(idx_lo);
      PAL_FRIGHT_BLUE:  rgb = FRIGHT_BLUE;
      PAL_FRIGHT_WHITE: rgb = FRIGHT_WHITE;
      default:          rgb = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/vga_pixel_compositor.sv
// rtl/vga_pixel_compositor.sv - three-stage layer compositor from ROM indices to DAC RGB
module vga_pixel_compositor
  import vga_pkg::*;
#(
  parameter int BLINK_FRAMES = 16,
  parameter int CIDX_W       = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_show_en,
  input  logic              i_hsync,
  input  logic              i_vsync,
  input  logic              i_frame_start,
  input  logic [1:0]        i_mem_select,
  input  logic [7:0]        i_address_map,
  input  logic [1:0]        i_address_item,
  input  logic [3:0]        i_which_char,
  input  logic [5:0]        i_tile_offset,
  input  logic [7:0]        i_char_offset,
  input  logic              i_fright,
  input  logic              i_fright_flash,
  output logic [13:0]       o_tile_rom_addr,
  input  logic [CIDX_W-1:0] i_tile_rom_data,
  output logic [7:0]        o_item_rom_addr,
  input  logic [CIDX_W-1:0] i_item_rom_data,
  output logic [11:0]       o_char_rom_addr,
  input  logic [CIDX_W-1:0] i_char_rom_data,
  output logic [7:0]        o_r,
  output logic [7:0]        o_g,
  output logic [7:0]        o_b,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_blank
);

  logic                s1_show, s2_show;
  logic [1:0]          s1_sel, s2_sel;
  logic [1:0]          s1_item, s2_item;
  logic [3:0]          s1_wc, s2_wc;
  logic                s1_fright, s2_fright;
  logic                s1_flash, s2_flash;
  logic [PIPE_LAT-1:0] hs_dly, vs_dly;

  logic [4:0]          blink_cnt;
  logic                blink_phase;

  logic                char_hit, item_hit, ghost;
  pal_class_e          res_cls;
  logic [CIDX_W-1:0]   res_idx;
  logic                res_blank;
  pixel_rgb_t          res_rgb;

  // S1 registers the ROM addresses; S2 carries sideband while the ROMs answer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_show         <= 1'b0;
      s1_sel          <= '0;
      s1_item         <= '0;
      s1_wc           <= '0;
      s1_fright       <= 1'b0;
      s1_flash        <= 1'b0;
      o_tile_rom_addr <= '0;
      o_item_rom_addr <= '0;
      o_char_rom_addr <= '0;
      s2_show         <= 1'b0;
      s2_sel          <= '0;
      s2_item         <= '0;
      s2_wc           <= '0;
      s2_fright       <= 1'b0;
      s2_flash        <= 1'b0;
    end else begin
      s1_show         <= i_show_en;
      s1_sel          <= i_mem_select;
      s1_item         <= i_address_item;
      s1_wc           <= i_which_char;
      s1_fright       <= i_fright;
      s1_flash        <= i_fright_flash;
      o_tile_rom_addr <= {i_address_map, i_tile_offset};
      o_item_rom_addr <= {i_address_item, i_tile_offset};
      o_char_rom_addr <= {i_which_char, i_char_offset};
      s2_show         <= s1_show;
      s2_sel          <= s1_sel;
      s2_item         <= s1_item;
      s2_wc           <= s1_wc;
      s2_fright       <= s1_fright;
      s2_flash        <= s1_flash;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hs_dly <= '1;
      vs_dly <= '1;
    end else begin
      hs_dly <= {hs_dly[PIPE_LAT-2:0], i_hsync};
      vs_dly <= {vs_dly[PIPE_LAT-2:0], i_vsync};
    end
  end

  assign o_hsync = hs_dly[PIPE_LAT-1];
  assign o_vsync = vs_dly[PIPE_LAT-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (i_frame_start) begin
      if (blink_cnt == 5'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 5'd1;
      end
    end
  end

  always_comb begin
    char_hit  = s2_sel[1] && (i_char_rom_data != '0) && (s2_wc <= CHAR_CLYDE);
    ghost     = s2_wc != CHAR_PACMAN;
    item_hit  = s2_sel[0] && (i_item_rom_data != '0) &&
                ((s2_item == ITEM_DOT) || (s2_item == ITEM_PELLET && !blink_phase));
    res_cls   = PAL_BLACK;
    res_idx   = '0;
    res_blank = 1'b0;
    if (!s2_show || s2_sel == 2'b00) begin
      res_blank = 1'b1;
    end else if (char_hit) begin
      if (ghost && s2_fright)
        res_cls = (s2_flash && blink_phase) ? PAL_FRIGHT_WHITE : PAL_FRIGHT_BLUE;
      else begin
        res_cls = PAL_INDEX;
        res_idx = i_char_rom_data;
      end
    end else if (item_hit) begin
      res_cls = PAL_INDEX;
      res_idx = i_item_rom_data;
    end else if (s2_sel[0]) begin
      res_cls = PAL_INDEX;
      res_idx = i_tile_rom_data;
    end
  end

  vga_palette_lut #(.CIDX_W(CIDX_W)) u_palette (
    .idx (res_idx),
    .cls (res_cls),
    .rgb (res_rgb)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_r     <= '0;
      o_g     <= '0;
      o_b     <= '0;
      o_blank <= 1'b1;
    end else begin
      o_r     <= res_rgb.r;
      o_g     <= res_rgb.g;
      o_b     <= res_rgb.b;
      o_blank <= res_blank;
    end
  end

endmodule

// File: tb/tb_vga_pixel_compositor.sv
// tb/tb_vga_pixel_compositor.sv - scoreboard bench for vga_pixel_compositor
module tb_vga_pixel_compositor;

  localparam int BF = 4;

  typedef struct {
    bit       show, hs, vs, fs, fr, fl;
    bit [1:0] sel, item;
    bit [7:0] map, coff;
    bit [3:0] wc;
    bit [5:0] toff;
  } stim_t;

  typedef struct {
    int        due;
    bit [26:0] px;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        show_en, hsync, vsync, frame_start, fright, fright_flash;
  logic [1:0]  mem_select, address_item;
  logic [7:0]  address_map, char_offset;
  logic [3:0]  which_char;
  logic [5:0]  tile_offset;
  logic [13:0] tile_addr;
  logic [7:0]  item_addr;
  logic [11:0] char_addr;
  logic [3:0]  tile_d = '0, item_d = '0, char_d = '0;
  logic [7:0]  r, g, b;
  logic        o_hs, o_vs, blank;

  logic [3:0]  tile_rom [16384];
  logic [3:0]  item_rom [256];
  logic [3:0]  char_rom [4096];
  logic [23:0] pal [16] = '{24'h000000, 24'hff0000, 24'hffb8ff, 24'h00ffff,
                            24'hffb852, 24'hffff00, 24'h2121ff, 24'hffb897,
                            24'hffffff, 24'h47b8ff, 24'h00ff00, 24'hde9751,
                            24'h21ffde, 24'h000000, 24'h000000, 24'h000000};
  localparam logic [23:0] BLUE  = 24'h2121de;
  localparam logic [23:0] WHITE = 24'hdedeff;

  int   cyc = 0, pulses = 0, n_cmp = 0, n_bad = 0;
  exp_t sbq[$];

  vga_pixel_compositor #(.BLINK_FRAMES(BF), .CIDX_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_show_en(show_en), .i_hsync(hsync), .i_vsync(vsync),
    .i_frame_start(frame_start), .i_mem_select(mem_select), .i_address_map(address_map),
    .i_address_item(address_item), .i_which_char(which_char), .i_tile_offset(tile_offset),
    .i_char_offset(char_offset), .i_fright(fright), .i_fright_flash(fright_flash),
    .o_tile_rom_addr(tile_addr), .i_tile_rom_data(tile_d),
    .o_item_rom_addr(item_addr), .i_item_rom_data(item_d),
    .o_char_rom_addr(char_addr), .i_char_rom_data(char_d),
    .o_r(r), .o_g(g), .o_b(b), .o_hsync(o_hs), .o_vsync(o_vs), .o_blank(blank)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    tile_d <= tile_rom[tile_addr];
    item_d <= item_rom[item_addr];
    char_d <= char_rom[char_addr];
  end

  // Pixel rules evaluated straight from the layer priority list.
  function automatic bit [26:0] model(input stim_t s, input bit ph);
    logic [3:0]  ci, ii, ti;
    logic [23:0] rgb;
    bit          bl;
    ci  = char_rom[{s.wc, s.coff}];
    ii  = item_rom[{s.item, s.toff}];
    ti  = tile_rom[{s.map, s.toff}];
    rgb = 24'h0;
    bl  = 1'b0;
    if (!s.show || s.sel == 2'b00) bl = 1'b1;
    else if (s.sel[1] && ci != 0 && s.wc <= 4) begin
      if (s.wc != 0 && s.fr) rgb = (s.fl && ph) ? WHITE : BLUE;
      else rgb = pal[ci];
    end else if (s.sel[0] && (s.item == 1 || s.item == 2) && ii != 0 && !(s.item == 2 && ph))
      rgb = pal[ii];
    else if (s.sel[0]) rgb = pal[ti];
    return {rgb, s.hs, s.vs, bl};
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{default: 0};
    s.hs = 1'($urandom);
    s.vs = 1'($urandom);
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.show = ($urandom_range(0, 99) < 85);
    s.hs   = 1'($urandom);
    s.vs   = 1'($urandom);
    s.fs   = ($urandom_range(0, 99) < 8);
    s.fr   = 1'($urandom);
    s.fl   = 1'($urandom);
    s.sel  = 2'($urandom);
    s.item = 2'($urandom);
    s.map  = 8'($urandom);
    s.coff = 8'($urandom);
    s.wc   = 4'($urandom_range(0, 7));
    s.toff = 6'($urandom);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    show_en = s.show; hsync = s.hs; vsync = s.vs; frame_start = s.fs;
    fright = s.fr; fright_flash = s.fl; mem_select = s.sel; address_item = s.item;
    address_map = s.map; char_offset = s.coff; which_char = s.wc; tile_offset = s.toff;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // An output pixel reflects frame pulses from inputs up to one cycle after it, so
  // each run is framed by pulse-free idle cycles to keep runs independent.
  task automatic run(input stim_t q_in[$]);
    stim_t q[$];
    bit    ph[$];
    exp_t  e;
    int    p;
    q = q_in;
    q.push_front(idle_stim());
    q.push_back(idle_stim());
    q.push_back(idle_stim());
    p = pulses;
    foreach (q[i]) begin
      p += int'(q[i].fs);
      ph.push_back(((p / BF) % 2) == 1);
    end
    foreach (q[i]) begin
      apply(q[i]);
      e.due = cyc + 3;
      e.px  = model(q[i], ph[(i + 1 < q.size()) ? i + 1 : i]);
      sbq.push_back(e);
      @(posedge clk); #1;
    end
    pulses = p;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rgb"}, {8'h0, r, g, b}, 32'h0);
    check({tag, "_sync_blank"}, {29'h0, o_hs, o_vs, blank}, 32'h7);
    check({tag, "_rom_addr"}, {6'h0, tile_addr, item_addr, char_addr} == 0, 32'h1);
  endtask

  // Reset is raised between edges; outputs must drop without waiting for a clock.
  task automatic do_reset();
    exp_t e;
    #2;
    rst = 1'b1;
    apply(rand_stim());
    frame_start = 1'b1;
    sbq.delete();
    pulses = 0;
    #1 check_reset_vals("reset_async");
    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset_hold");
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e.due = cyc + k;
      e.px  = {24'h0, 3'b111};
      sbq.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      e = sbq.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL pixel_missed: due %0d now %0d", e.due, cyc);
    end
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      n_cmp++;
      if ({r, g, b, o_hs, o_vs, blank} !== e.px) begin
        n_bad++;
        $display("FAIL pixel@%0d: got rgb=%h hs=%b vs=%b blank=%b expected rgb=%h hs=%b vs=%b blank=%b",
                 cyc, {r, g, b}, o_hs, o_vs, blank, e.px[26:3], e.px[2], e.px[1], e.px[0]);
      end
    end
  end

  initial begin
    stim_t q[$];
    stim_t s, pp, pd, fp, gb, gf, pm;
    foreach (tile_rom[i]) tile_rom[i] = 4'($urandom_range(0, 15));
    foreach (item_rom[i]) item_rom[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
    foreach (char_rom[i]) char_rom[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
    char_rom[{4'd1, 8'd10}] = 4'd5;  char_rom[{4'd1, 8'd11}] = 4'd0;
    item_rom[{2'd1, 6'd10}] = 4'd3;  item_rom[{2'd1, 6'd12}] = 4'd0;
    tile_rom[{8'd20, 6'd10}] = 4'd2; tile_rom[{8'd20, 6'd12}] = 4'd2;
    item_rom[{2'd2, 6'd20}] = 4'd7;  item_rom[{2'd1, 6'd20}] = 4'd7;
    tile_rom[{8'd30, 6'd20}] = 4'd2;
    char_rom[{4'd2, 8'd30}] = 4'd9;  char_rom[{4'd0, 8'd30}] = 4'd9;
    apply(idle_stim());

    @(posedge clk); #1;
    do_reset();

    s = idle_stim(); s.show = 1; s.sel = 2'b11; s.wc = 1; s.item = 1; s.map = 20;
    s.coff = 10; s.toff = 10; q.push_back(s);
    s.coff = 11; q.push_back(s);
    s.toff = 12; q.push_back(s);
    s.wc = 5; s.coff = 10; s.toff = 10; q.push_back(s);
    run(q);

    q.delete();
    repeat (300) q.push_back(rand_stim());
    run(q);
    do_reset();

    pp = idle_stim(); pp.show = 1; pp.sel = 2'b01; pp.item = 2; pp.toff = 20; pp.map = 30;
    pd = pp; pd.item = 1;
    fp = idle_stim(); fp.fs = 1;
    q.delete();
    q.push_back(pp);
    for (int k = 1; k <= 9; k++) begin
      q.push_back(fp); q.push_back(pp); q.push_back(pd);
    end
    run(q);

    gb = idle_stim(); gb.show = 1; gb.sel = 2'b10; gb.wc = 2; gb.coff = 30; gb.fr = 1;
    gf = gb; gf.fl = 1;
    pm = gf; pm.wc = 0;
    q.delete();
    for (int k = 0; k < 8; k++) begin
      q.push_back(gb); q.push_back(gf); q.push_back(pm); q.push_back(fp);
    end
    run(q);

    q.delete();
    repeat (300) q.push_back(rand_stim());
    run(q);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
